// File: rtl/dpi_pkg.sv
// Shared types and default geometry for the DPI window writer and its scan-driver peer.
package dpi_pkg;

  localparam int WIN_X0_DEF = 100;
  localparam int WIN_Y0_DEF = 50;
  localparam int WIN_W_DEF  = 64;
  localparam int WIN_H_DEF  = 32;
  localparam int BPC_DEF    = 4;

  localparam int XW = $clog2(WIN_W_DEF);
  localparam int YW = $clog2(WIN_H_DEF);
  localparam int AW = 1 + YW + XW;
  localparam int DW = 3 * BPC_DEF;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAPTURE,
    FLUSH,
    WAIT_ACK,
    WAIT_REL
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == DROP_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dpi_window_writer.sv
// Crops a fixed window from the DPI pixel stream into a double-buffered frame RAM
// and hands completed frames to the scan driver with a four-phase bank swap.
module dpi_window_writer
  import dpi_pkg::*;
#(
  parameter int WIN_X0 = WIN_X0_DEF,
  parameter int WIN_Y0 = WIN_Y0_DEF,
  parameter int WIN_W  = WIN_W_DEF,
  parameter int WIN_H  = WIN_H_DEF,
  parameter int BPC    = BPC_DEF,
  localparam int XB    = $clog2(WIN_W),
  localparam int YB    = $clog2(WIN_H),
  localparam int AB    = 1 + YB + XB,
  localparam int DB    = 3 * BPC
) (
  input  logic          PCLK,
  input  logic          RESET,
  input  logic          VSYNC,
  input  logic          PIX_VALID,
  input  logic [10:0]   PIX_X,
  input  logic [9:0]    PIX_Y,
  input  logic [7:0]    PIX_R,
  input  logic [7:0]    PIX_G,
  input  logic [7:0]    PIX_B,
  input  logic          BUF_TAKEN,
  output logic          WR_EN,
  output logic [AB-1:0] WR_ADDR,
  output logic [DB-1:0] WR_DATA,
  output logic          WR_BANK,
  output logic          BUF_READY,
  output logic [7:0]    DROP_CNT
);

  state_t        state;
  logic          vsync_q;
  logic          last_q;
  logic          taken_sync;
  logic [11:0]   dx;
  logic [11:0]   dy;
  logic [XB-1:0] x_rel;
  logic [YB-1:0] y_rel;
  logic          in_win;
  logic          pix_ok;
  logic          vsync_rise;
  logic          drop_inc;

  sync_2ff u_taken_sync (
    .clk (PCLK),
    .rst (RESET),
    .d   (BUF_TAKEN),
    .q   (taken_sync)
  );

  // Left/above-window coordinates wrap to large values and fail the compare.
  always_comb begin
    dx         = {1'b0, PIX_X} - 12'(WIN_X0);
    dy         = {2'b0, PIX_Y} - 12'(WIN_Y0);
    x_rel      = dx[XB-1:0];
    y_rel      = dy[YB-1:0];
    in_win     = (dx < 12'(WIN_W)) && (dy < 12'(WIN_H));
    pix_ok     = PIX_VALID && !VSYNC && in_win;
    vsync_rise = VSYNC && !vsync_q;
    drop_inc   = 1'b0;
    case (state)
      CAPTURE:                   drop_inc = last_q ? vsync_rise : VSYNC;
      FLUSH, WAIT_ACK, WAIT_REL: drop_inc = vsync_rise;
      default:                   drop_inc = 1'b0;
    endcase
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      vsync_q   <= 1'b0;
      last_q    <= 1'b0;
      WR_EN     <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
      WR_BANK   <= 1'b0;
      BUF_READY <= 1'b0;
      DROP_CNT  <= '0;
    end else begin
      vsync_q <= VSYNC;
      WR_EN   <= 1'b0;
      if (drop_inc) DROP_CNT <= sat_inc(DROP_CNT);

      case (state)
        IDLE:  if (VSYNC)  state <= ARMED;
        ARMED: if (!VSYNC) state <= CAPTURE;
        CAPTURE: begin
          // last_q holds CAPTURE one extra cycle so the final write commits first.
          if (last_q) begin
            last_q <= 1'b0;
            state  <= FLUSH;
          end else if (VSYNC) begin
            state <= ARMED;
          end else if (pix_ok) begin
            WR_EN   <= 1'b1;
            WR_ADDR <= {WR_BANK, y_rel, x_rel};
            WR_DATA <= {PIX_R[7-:BPC], PIX_G[7-:BPC], PIX_B[7-:BPC]};
            last_q  <= (&x_rel) && (&y_rel);
          end
        end
        FLUSH: begin
          BUF_READY <= 1'b1;
          state     <= WAIT_ACK;
        end
        WAIT_ACK: if (taken_sync) begin
          WR_BANK   <= ~WR_BANK;
          BUF_READY <= 1'b0;
          state     <= WAIT_REL;
        end
        WAIT_REL: if (!taken_sync) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpi_window_writer.sv
// Randomised bench for dpi_window_writer against a coordinate-level expected-write model.
module tb_dpi_window_writer;
  import dpi_pkg::*;

  localparam int X0 = 100;
  localparam int Y0 = 50;
  localparam int W  = 64;
  localparam int H  = 32;

  logic          PCLK, RESET, VSYNC, PIX_VALID, BUF_TAKEN;
  logic [10:0]   PIX_X;
  logic [9:0]    PIX_Y;
  logic [7:0]    PIX_R, PIX_G, PIX_B;
  logic          WR_EN, WR_BANK, BUF_READY;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic [7:0]    DROP_CNT;

  dpi_window_writer dut (
    .PCLK(PCLK), .RESET(RESET), .VSYNC(VSYNC), .PIX_VALID(PIX_VALID),
    .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_R(PIX_R), .PIX_G(PIX_G), .PIX_B(PIX_B),
    .BUF_TAKEN(BUF_TAKEN), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .WR_BANK(WR_BANK), .BUF_READY(BUF_READY), .DROP_CNT(DROP_CNT)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  capture_on = 1'b0;
  int  bank_m = 0;
  int  cyc = 0, wr_count = 0, last_wr_cyc = 0, ready_rise_cyc = 0;
  bit  ready_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected pixel.
  always begin
    @(posedge PCLK);
    #1;
    cyc++;
    if (WR_EN === 1'b1) begin
      wr_count++;
      last_wr_cyc = cyc;
      check("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", WR_ADDR, e.addr);
        check("wr_data", WR_DATA, e.data);
      end
    end
    if (BUF_READY && !ready_prev) ready_rise_cyc = cyc;
    ready_prev = BUF_READY;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge PCLK);
      PIX_VALID = 1'b0;
    end
  endtask

  task automatic drive_pix(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b);
    wr_t e;
    @(negedge PCLK);
    PIX_VALID = 1'b1;
    PIX_X = 11'(x);
    PIX_Y = 10'(y);
    PIX_R = r;
    PIX_G = g;
    PIX_B = b;
    if (capture_on && !VSYNC && x >= X0 && x < X0 + W && y >= Y0 && y < Y0 + H) begin
      e.addr = AW'(bank_m * W * H + (y - Y0) * W + (x - X0));
      e.data = {r[7:4], g[7:4], b[7:4]};
      exp_q.push_back(e);
      if (x == X0 + W - 1 && y == Y0 + H - 1) capture_on = 1'b0;
    end
  endtask

  task automatic vsync_pulse();
    @(negedge PCLK);
    PIX_VALID = 1'b0;
    VSYNC = 1'b1;
    repeat (3) @(negedge PCLK);
    VSYNC = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic raster(input int x_lo, input int x_hi, input int y_lo, input int y_hi,
                        input int max_win);
    int nwin = 0;
    for (int y = y_lo; y <= y_hi; y++) begin
      for (int x = x_lo; x <= x_hi; x++) begin
        if ($urandom_range(0, 7) == 0) idle(1);
        if (x >= X0 && x < X0 + W && y >= Y0 && y < Y0 + H) nwin++;
        drive_pix(x, y, 8'($urandom), 8'($urandom), 8'($urandom));
        if (max_win > 0 && nwin >= max_win) begin
          idle(1);
          return;
        end
      end
    end
    idle(1);
  endtask

  task automatic handshake(input int new_bank);
    int edges = 0;
    @(negedge PCLK);
    BUF_TAKEN = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge PCLK);
      #1;
      edges = i;
      if (!BUF_READY) break;
    end
    check("ack_within_2_to_3_edges", edges >= 2 && edges <= 3, 1);
    check("bank_after_swap", WR_BANK, new_bank);
    check("ready_after_swap", BUF_READY, 0);
    @(negedge PCLK);
    BUF_TAKEN = 1'b0;
    idle(4);
    bank_m = new_bank;
  endtask

  initial begin
    RESET = 1'b1; VSYNC = 1'b0; PIX_VALID = 1'b0; BUF_TAKEN = 1'b0;
    PIX_X = '0; PIX_Y = '0; PIX_R = '0; PIX_G = '0; PIX_B = '0;
    idle(3);
    check("rst_wr_en", WR_EN, 0);
    check("rst_wr_addr", WR_ADDR, 0);
    check("rst_wr_data", WR_DATA, 0);
    check("rst_wr_bank", WR_BANK, 0);
    check("rst_buf_ready", BUF_READY, 0);
    check("rst_drop_cnt", DROP_CNT, 0);
    RESET = 1'b0;

    // No capture before a complete VSYNC pulse.
    drive_pix(X0, Y0, 8'hFF, 8'h80, 8'h0F);
    @(posedge PCLK); #1;
    check("no_write_before_vsync", WR_EN, 0);

    vsync_pulse();
    capture_on = 1'b1;
    drive_pix(X0, Y0, 8'hFF, 8'h80, 8'h0F);
    @(posedge PCLK); #1;
    check("first_wr_en", WR_EN, 1);
    check("first_wr_addr", WR_ADDR, 'h000);
    check("first_wr_data", WR_DATA, 'hF80);
    drive_pix(X0 - 1, Y0, 8'h11, 8'h22, 8'h33);
    @(posedge PCLK); #1;
    check("left_of_window", WR_EN, 0);
    drive_pix(X0, Y0 - 1, 8'h11, 8'h22, 8'h33);
    @(posedge PCLK); #1;
    check("above_window", WR_EN, 0);

    wr_count = 0;
    raster(90, 170, 45, 85, 0);
    idle(4);
    check("frame1_writes", wr_count, 2048);
    check("frame1_last_addr", WR_ADDR, 'h7FF);
    check("ready_latency", ready_rise_cyc - last_wr_cyc, 2);
    check("frame1_ready", BUF_READY, 1);
    check("frame1_queue_drained", exp_q.size(), 0);

    handshake(1);
    vsync_pulse();
    capture_on = 1'b1;
    drive_pix(X0, Y0, 8'($urandom), 8'($urandom), 8'($urandom));
    @(posedge PCLK); #1;
    check("bank1_first_en", WR_EN, 1);
    check("bank1_first_addr", WR_ADDR, 'h800);
    raster(90, 170, 45, 85, 0);
    idle(4);
    check("frame2_ready", BUF_READY, 1);
    check("frame2_last_addr", WR_ADDR, 'hFFF);

    // Reader holds off: three further frames are dropped.
    wr_count = 0;
    repeat (3) begin
      vsync_pulse();
      raster(95, 110, 48, 53, 0);
    end
    idle(2);
    check("drop_no_writes", wr_count, 0);
    check("drop_cnt_3", DROP_CNT, 3);
    check("drop_bank_held", WR_BANK, 1);
    check("drop_ready_held", BUF_READY, 1);
    handshake(0);

    // Abort after 1000 window writes.
    vsync_pulse();
    capture_on = 1'b1;
    wr_count = 0;
    raster(90, 170, 45, 85, 1000);
    idle(2);
    check("abort_writes", wr_count, 1000);
    @(negedge PCLK);
    VSYNC = 1'b1;
    capture_on = 1'b0;
    @(posedge PCLK); #1;
    check("abort_drop_cnt", DROP_CNT, 4);
    check("abort_ready_low", BUF_READY, 0);
    @(negedge PCLK);
    VSYNC = 1'b0;
    @(negedge PCLK);
    capture_on = 1'b1;
    drive_pix(X0, Y0, 8'($urandom), 8'($urandom), 8'($urandom));
    @(posedge PCLK); #1;
    check("restart_en", WR_EN, 1);
    check("restart_addr", WR_ADDR, 'h000);

    // Reset while a write strobe is active mid-CAPTURE.
    drive_pix(X0 + 1, Y0, 8'hAB, 8'hCD, 8'hEF);
    @(posedge PCLK); #2;
    RESET = 1'b1;
    capture_on = 1'b0;
    exp_q.delete();
    bank_m = 0;
    #1;
    check("rstcap_wr_en", WR_EN, 0);
    check("rstcap_wr_addr", WR_ADDR, 0);
    check("rstcap_wr_data", WR_DATA, 0);
    check("rstcap_drop_cnt", DROP_CNT, 0);
    idle(2);
    RESET = 1'b0;
    wr_count = 0;
    raster(95, 110, 48, 53, 0);
    idle(2);
    check("rstcap_no_writes", wr_count, 0);
    vsync_pulse();
    capture_on = 1'b1;
    raster(90, 170, 45, 85, 0);
    idle(4);
    check("frame3_writes", wr_count, 2048);
    check("frame3_ready", BUF_READY, 1);

    // Drop counter saturation while waiting for the reader.
    repeat (260) vsync_pulse();
    check("drop_saturates", DROP_CNT, 255);
    check("sat_bank_held", WR_BANK, 0);

    // Reset mid-WAIT_ACK.
    @(negedge PCLK);
    RESET = 1'b1;
    #1;
    check("rstack_ready", BUF_READY, 0);
    check("rstack_drop_cnt", DROP_CNT, 0);
    check("rstack_wr_addr", WR_ADDR, 0);
    check("rstack_wr_data", WR_DATA, 0);
    idle(2);
    RESET = 1'b0;
    wr_count = 0;
    raster(95, 110, 48, 53, 0);
    idle(2);
    check("rstack_no_writes", wr_count, 0);
    vsync_pulse();
    capture_on = 1'b1;
    drive_pix(X0, Y0, 8'($urandom), 8'($urandom), 8'($urandom));
    @(posedge PCLK); #1;
    check("post_reset_en", WR_EN, 1);
    check("post_reset_addr", WR_ADDR, 'h000);
    idle(2);
    check("final_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dpi_window_writer.md
# dpi_window_writer

Downstream stage of the 24-bit DPI receiver. It takes the receiver's pixel stream, with coordinates attached, and crops a fixed WIN_W×WIN_H window. Each pixel in the window is reduced to BPC bits per colour and written into a double-buffered frame RAM. A completed frame is handed to the LED-matrix scan driver through a four-phase bank-swap handshake.

## Interface
- WIN_X0, 100: first captured column (input pixel coordinates)
- WIN_Y0, 50: first captured line
- WIN_W, 64: window width; power of two
- WIN_H, 32: window height; power of two
- BPC, 4: output bits per colour, 1..8
- PCLK  in  1  pixel clock; all logic is in this domain
- RESET  in  1  asynchronous, active-high
- VSYNC  in  1  active-high, level, PCLK domain
- PIX_VALID  in  1  PIX_X/PIX_Y/PIX_R/G/B valid this cycle, all coincident
- PIX_X  in  11  column
- PIX_Y  in  10  line
- PIX_R, PIX_G, PIX_B  in  8 each  colour
- BUF_TAKEN  in  1  reader-domain level, asynchronous to PCLK
- WR_EN  out  1  RAM write strobe
- WR_ADDR  out  1+log2(WIN_H)+log2(WIN_W)  {WR_BANK, y_rel, x_rel}
- WR_DATA  out  3*BPC  {R, G, B}, each truncated to its top BPC bits
- WR_BANK  out  1  bank being written; the reader uses ~WR_BANK
- BUF_READY  out  1  completed frame waiting in WR_BANK
- DROP_CNT  out  8  dropped/aborted frames, saturating

## Operation
- Reset values: WR_EN=0, WR_ADDR=0, WR_DATA=0, WR_BANK=0, BUF_READY=0, DROP_CNT=0, state IDLE, synchroniser flops 0. All outputs are registered.
- In-window test: PIX_X-WIN_X0 < WIN_W and PIX_Y-WIN_Y0 < WIN_H.
  - Use 12-bit unsigned subtraction, so coordinates left of or above the window wrap large and fail the test.
  - x_rel and y_rel are the low log2 bits of those differences.
- A pixel with PIX_VALID=1 while VSYNC=1 is always ignored.
- FSM states:
  - IDLE: on VSYNC=1 → ARMED.
  - ARMED: on VSYNC=0 → CAPTURE. This is the frame start. The first frame after reset is captured only after a complete VSYNC pulse has been seen.
  - CAPTURE: each in-window valid pixel produces one write.
    - Write of (x_rel=WIN_W-1, y_rel=WIN_H-1) → FLUSH.
    - VSYNC=1 before that write → ARMED. The frame is aborted, DROP_CNT++, and WR_BANK is unchanged. Partial data in WR_BANK is overwritten by the next frame.
  - FLUSH: one cycle, so the last write commits → WAIT_ACK with BUF_READY=1.
  - WAIT_ACK: synced BUF_TAKEN=1 → toggle WR_BANK, BUF_READY=0, → WAIT_REL.
  - WAIT_REL: synced BUF_TAKEN=0 → IDLE.
- Dropped frames: each VSYNC rising edge seen while in FLUSH, WAIT_ACK or WAIT_REL does DROP_CNT++. Input is discarded until the handshake completes.
- DROP_CNT saturates at 255 and is cleared only by RESET.
- Simultaneous events:
  - Abort and drop in the same cycle count once.
  - A VSYNC rising edge in the same cycle as BUF_TAKEN sync in WAIT_ACK: the swap happens and the edge counts as a drop.
- Reset mid-operation: everything returns to reset values and the bank returns to 0. The reader must treat RESET as invalidating both banks.

## Timing
- Write latency is 1: a pixel sampled at edge N gives WR_EN/WR_ADDR/WR_DATA valid from edge N until edge N+1.
- WR_EN is a single-cycle pulse per pixel; back-to-back pixels give continuous WR_EN.
- BUF_READY rises 2 edges after the last write's WR_EN pulse (edge N+1 into FLUSH, edge N+2 into WAIT_ACK).
- BUF_TAKEN passes through a 2-flop synchroniser. The WR_BANK toggle and BUF_READY fall occur on the 3rd PCLK edge after BUF_TAKEN rises (2–3 edges, depending on phase).
- Reader obligations:
  - Raise BUF_TAKEN only while BUF_READY=1.
  - Hold BUF_TAKEN until it sees BUF_READY=0, then lower it.
  - Switch to the new read bank after lowering BUF_TAKEN.
- VSYNC edge detection uses one registered VSYNC, so detection lags by 1 cycle.

## Structure
- Package dpi_pkg:
  - state enum (IDLE, ARMED, CAPTURE, FLUSH, WAIT_ACK, WAIT_REL)
  - localparams XW=$clog2(WIN_W), YW=$clog2(WIN_H), AW=1+YW+XW, DW=3*BPC
  - DROP_MAX=8'hFF
- Sub-module sync_2ff (single-bit, 2-flop, async reset to 0) for BUF_TAKEN. It is reused by the scan driver for the reverse direction.

## Test plan
All scenarios use default parameters.
- Pixel (100,50) RGB=FF/80/0F after a VSYNC pulse → one cycle later WR_EN=1, WR_ADDR=0x000, WR_DATA=0xF80. Pixels (99,50) and (100,49) → no write.
- Full raster of 640×480 → exactly 2048 writes. The last write is at (163,81), WR_ADDR=0x7FF. BUF_READY rises 2 cycles later.
- Raise BUF_TAKEN → WR_BANK=1 and BUF_READY=0 within 3 edges. Drop BUF_TAKEN, then send the next frame → the first write has WR_ADDR=0x800.
- Hold BUF_TAKEN low across 3 further VSYNC pulses → no writes, DROP_CNT=3, WR_BANK unchanged.
- Assert VSYNC after 1000 window writes → FSM returns to ARMED, DROP_CNT increments, BUF_READY stays 0, and the next frame restarts at WR_ADDR=0x000.
- Assert RESET mid-CAPTURE and mid-WAIT_ACK → all outputs go to reset values immediately. No write occurs until a full VSYNC pulse.
